// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory-port arbiter:
// controller states, owner encoding and default widths.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      IBUSY = 2'd1,
      DBUSY = 2'd2
   } arbState_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;

   // Bits needed to hold 0..maxVal; never narrower than one bit.
   function automatic int cntWidth(input int maxVal);
      return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational priority picker: data wins unless the fetch side is starved.
module mem_arb_pick (
   input  logic ibus_req_i,
   input  logic dbus_req_i,
   input  logic starve_full_i,
   output logic grant_i_o,
   output logic grant_d_o
);

   assign grant_i_o = ibus_req_i & (starve_full_i | ~dbus_req_i);
   assign grant_d_o = dbus_req_i & ~grant_i_o;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and data buses, with
// fetch starvation protection and a watchdog that aborts hung accesses.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = DEF_ADDR_W,
   parameter int DATA_W       = DEF_DATA_W,
   parameter int STARVE_LIMIT = 4,
   parameter int TIMEOUT      = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ibus_req,
   input  logic [ADDR_W-1:0] ibus_addr,
   output logic [DATA_W-1:0] ibus_data,
   output logic              ibus_ready,
   input  logic              dbus_rd,
   input  logic              dbus_wr,
   input  logic [ADDR_W-1:0] dbus_addr,
   input  logic [DATA_W-1:0] dbus_data_wr,
   output logic [DATA_W-1:0] dbus_data_rd,
   output logic              dbus_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rd,
   output logic              mem_wr,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic              err
);

   localparam int SW = cntWidth(STARVE_LIMIT);
   localparam int TW = cntWidth(TIMEOUT);

   arbState_e         state_q;
   logic [ADDR_W-1:0] memAddr_q;
   logic [DATA_W-1:0] memWdata_q;
   logic              memRd_q;
   logic              memWr_q;
   logic [SW-1:0]     starveCnt_q;
   logic [SW-1:0]     starveCnt_d;
   logic [TW-1:0]     tmoCnt_q;

   logic              dReq;
   logic              starveFull;
   logic              grantI;
   logic              grantD;
   logic              busyNow;
   logic              timeoutHit;
   logic              finish;
   owner_e            owner;
   logic [DATA_W-1:0] readData;

   assign dReq       = dbus_rd | dbus_wr;
   assign starveFull = (starveCnt_q == SW'(STARVE_LIMIT));
   assign busyNow    = (state_q != IDLE);
   assign timeoutHit = (TIMEOUT != 0) && (tmoCnt_q == TW'(TIMEOUT - 1));
   // A same-cycle mem_ready takes precedence over the watchdog.
   assign finish     = busyNow && (mem_ready || timeoutHit);

   mem_arb_pick uPick (
      .ibus_req_i    (ibus_req),
      .dbus_req_i    (dReq),
      .starve_full_i (starveFull),
      .grant_i_o     (grantI),
      .grant_d_o     (grantD)
   );

   always_comb begin
      starveCnt_d = starveCnt_q;
      if (state_q == IDLE) begin
         if (!ibus_req || grantI) begin
            starveCnt_d = '0;
         end else if (grantD && !starveFull) begin
            starveCnt_d = starveCnt_q + SW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         memAddr_q   <= '0;
         memWdata_q  <= '0;
         memRd_q     <= 1'b0;
         memWr_q     <= 1'b0;
         starveCnt_q <= '0;
         tmoCnt_q    <= '0;
      end else begin
         starveCnt_q <= starveCnt_d;
         case (state_q)
            IDLE: begin
               tmoCnt_q <= '0;
               if (grantI) begin
                  state_q   <= IBUSY;
                  memAddr_q <= ibus_addr;
                  memRd_q   <= 1'b1;
                  memWr_q   <= 1'b0;
               end else if (grantD) begin
                  state_q   <= DBUSY;
                  memAddr_q <= dbus_addr;
                  if (dbus_wr) begin
                     memWdata_q <= dbus_data_wr;
                     memRd_q    <= 1'b0;
                     memWr_q    <= 1'b1;
                  end else begin
                     memRd_q <= 1'b1;
                     memWr_q <= 1'b0;
                  end
               end
            end
            IBUSY, DBUSY: begin
               if (finish) begin
                  state_q <= IDLE;
                  memRd_q <= 1'b0;
                  memWr_q <= 1'b0;
               end
               if (tmoCnt_q != '1) begin
                  tmoCnt_q <= tmoCnt_q + TW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
               memRd_q <= 1'b0;
               memWr_q <= 1'b0;
            end
         endcase
      end
   end

   assign owner    = (state_q == DBUSY) ? OWN_D : OWN_I;
   assign readData = (mem_ready && memRd_q) ? mem_rdata : '0;

   assign ibus_ready   = finish && (owner == OWN_I);
   assign dbus_ready   = finish && (owner == OWN_D);
   assign ibus_data    = ibus_ready ? readData : '0;
   assign dbus_data_rd = dbus_ready ? readData : '0;
   assign err          = busyNow && timeoutHit && !mem_ready;
   assign busy         = busyNow;

   assign mem_addr  = memAddr_q;
   assign mem_wdata = memWdata_q;
   assign mem_rd    = memRd_q;
   assign mem_wr    = memWr_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic checked against a transaction-level arbitration model.
module tb_mem_arbiter;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int LIMIT = 4;
   localparam int TMO   = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          ibus_req;
   logic [AW-1:0] ibus_addr;
   logic [DW-1:0] ibus_data;
   logic          ibus_ready;
   logic          dbus_rd;
   logic          dbus_wr;
   logic [AW-1:0] dbus_addr;
   logic [DW-1:0] dbus_data_wr;
   logic [DW-1:0] dbus_data_rd;
   logic          dbus_ready;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_rd;
   logic          mem_wr;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic          busy;
   logic          err;

   mem_arbiter #(
      .ADDR_W       (AW),
      .DATA_W       (DW),
      .STARVE_LIMIT (LIMIT),
      .TIMEOUT      (TMO)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .ibus_req     (ibus_req),
      .ibus_addr    (ibus_addr),
      .ibus_data    (ibus_data),
      .ibus_ready   (ibus_ready),
      .dbus_rd      (dbus_rd),
      .dbus_wr      (dbus_wr),
      .dbus_addr    (dbus_addr),
      .dbus_data_wr (dbus_data_wr),
      .dbus_data_rd (dbus_data_rd),
      .dbus_ready   (dbus_ready),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rd       (mem_rd),
      .mem_wr       (mem_wr),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready),
      .busy         (busy),
      .err          (err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Requester intent: what each bus wants, held until its ready.
   logic        fPend = 1'b0;
   logic [31:0] fAddr = '0;
   logic        dPend = 1'b0;
   logic        dWr   = 1'b0;
   logic        dBoth = 1'b0;
   logic        dHold = 1'b0;
   logic [31:0] dAddr = '0;
   logic [31:0] dWdata = '0;
   logic        arrivals = 1'b0;

   // Model: consecutive data wins while a fetch waits, and the expected access.
   int          starveModel = 0;
   int          own = 0;
   logic [31:0] expAddr = '0;
   logic [31:0] expWdata = '0;
   logic        expRd = 1'b0;
   logic        expWr = 1'b0;
   int          ownLog[$];
   int          expSeq[6] = '{2, 2, 2, 2, 1, 2};

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus();
      ibus_req     = fPend;
      ibus_addr    = fAddr;
      dbus_rd      = dPend && (!dWr || dBoth);
      dbus_wr      = dPend && dWr;
      dbus_addr    = dAddr;
      dbus_data_wr = dWdata;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic newFetch();
      fPend = 1'b1;
      fAddr = $urandom & 32'hFFFF_FFFC;
   endtask

   task automatic newData();
      dPend  = 1'b1;
      dWr    = ($urandom_range(1) == 1);
      dBoth  = dWr && ($urandom_range(1) == 1);
      dAddr  = $urandom & 32'hFFFF_FFFC;
      dWdata = $urandom;
   endtask

   // Idle cycle where the arbiter picks an owner from the current requests.
   task automatic grantStep();
      applyStimulus();
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      #1;
      checkOutput("idle busy", 32'(busy), 32'h0);
      checkOutput("idle mem_rd", 32'(mem_rd), 32'h0);
      checkOutput("idle mem_wr", 32'(mem_wr), 32'h0);
      checkOutput("idle ibus_ready", 32'(ibus_ready), 32'h0);
      checkOutput("idle dbus_ready", 32'(dbus_ready), 32'h0);
      checkOutput("idle err", 32'(err), 32'h0);
      if (fPend && (starveModel == LIMIT || !dPend)) begin
         own = 1;
         starveModel = 0;
         expAddr = fAddr;
         expRd = 1'b1;
         expWr = 1'b0;
      end else if (dPend) begin
         own = 2;
         starveModel = fPend ? ((starveModel < LIMIT) ? starveModel + 1 : LIMIT) : 0;
         expAddr = dAddr;
         expWr = dWr;
         expRd = !dWr;
         expWdata = dWdata;
      end else begin
         own = 0;
         starveModel = 0;
      end
      nextCycle();
   endtask

   // Access in flight; memory answers after lat wait cycles (lat<0: never).
   task automatic busyStep(input int lat, input logic [31:0] rdata);
      for (int k = 0; k < TMO + 4; k++) begin
         bit done;
         int obsOwn;
         if (arrivals && own == 1 && !dPend && $urandom_range(3) == 0) newData();
         if (arrivals && own == 2 && !fPend && $urandom_range(3) == 0) newFetch();
         mem_ready = (k == lat);
         mem_rdata = (k == lat) ? rdata : $urandom;
         applyStimulus();
         #1;
         checkOutput("busy flag", 32'(busy), 32'h1);
         checkOutput("mem_rd", 32'(mem_rd), 32'(expRd));
         checkOutput("mem_wr", 32'(mem_wr), 32'(expWr));
         checkOutput("mem_addr", mem_addr, expAddr);
         if (expWr) checkOutput("mem_wdata", mem_wdata, expWdata);
         done = (k == lat) || (k == TMO - 1);
         if (k == lat) begin
            checkOutput("ibus_ready", 32'(ibus_ready), (own == 1) ? 32'h1 : 32'h0);
            checkOutput("dbus_ready", 32'(dbus_ready), (own == 2) ? 32'h1 : 32'h0);
            checkOutput("ibus_data", ibus_data, (own == 1) ? rdata : 32'h0);
            checkOutput("dbus_data_rd", dbus_data_rd, (own == 2 && expRd) ? rdata : 32'h0);
            checkOutput("err on completion", 32'(err), 32'h0);
         end else if (k == TMO - 1) begin
            checkOutput("abort ibus_ready", 32'(ibus_ready), (own == 1) ? 32'h1 : 32'h0);
            checkOutput("abort dbus_ready", 32'(dbus_ready), (own == 2) ? 32'h1 : 32'h0);
            checkOutput("abort ibus_data", ibus_data, 32'h0);
            checkOutput("abort dbus_data_rd", dbus_data_rd, 32'h0);
            checkOutput("abort err", 32'(err), 32'h1);
         end else begin
            checkOutput("wait ibus_ready", 32'(ibus_ready), 32'h0);
            checkOutput("wait dbus_ready", 32'(dbus_ready), 32'h0);
            checkOutput("wait ibus_data", ibus_data, 32'h0);
            checkOutput("wait dbus_data_rd", dbus_data_rd, 32'h0);
            checkOutput("wait err", 32'(err), 32'h0);
         end
         if (done) begin
            obsOwn = ibus_ready ? 1 : (dbus_ready ? 2 : 0);
            ownLog.push_back(obsOwn);
            if (own == 1) begin
               fPend = 1'b0;
            end else if (dHold) begin
               dAddr  = dAddr + 32'h4;
               dWdata = $urandom;
            end else begin
               dPend = 1'b0;
            end
         end
         nextCycle();
         if (done) break;
      end
      mem_ready = 1'b0;
   endtask

   // mem_ready while nobody owns the port must produce nothing.
   task automatic idleProbe();
      applyStimulus();
      mem_ready = 1'b1;
      mem_rdata = $urandom;
      #1;
      checkOutput("stray ibus_ready", 32'(ibus_ready), 32'h0);
      checkOutput("stray dbus_ready", 32'(dbus_ready), 32'h0);
      checkOutput("stray ibus_data", ibus_data, 32'h0);
      checkOutput("stray dbus_data_rd", dbus_data_rd, 32'h0);
      checkOutput("stray busy", 32'(busy), 32'h0);
      starveModel = 0;
      nextCycle();
      mem_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      applyStimulus();
      #1 reset = 1'b1;
      #2;
      checkOutput("reset mem_addr", mem_addr, 32'h0);
      checkOutput("reset mem_wdata", mem_wdata, 32'h0);
      checkOutput("reset mem_rd", 32'(mem_rd), 32'h0);
      checkOutput("reset mem_wr", 32'(mem_wr), 32'h0);
      checkOutput("reset ibus_ready", 32'(ibus_ready), 32'h0);
      checkOutput("reset dbus_ready", 32'(dbus_ready), 32'h0);
      checkOutput("reset busy", 32'(busy), 32'h0);
      checkOutput("reset err", 32'(err), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Lone fetch, three strobe cycles.
      fPend = 1'b1; fAddr = 32'h100;
      grantStep();
      busyStep(2, 32'hDEAD_BEEF);

      // Fetch and data read together: data first, fetch right after.
      fPend = 1'b1; fAddr = 32'h0;
      dPend = 1'b1; dWr = 1'b0; dBoth = 1'b0; dAddr = 32'h40;
      grantStep();
      busyStep(1, 32'h1111_2222);
      grantStep();
      busyStep(0, 32'h3333_4444);

      // Held write stream against a waiting fetch.
      ownLog.delete();
      fPend = 1'b1; fAddr = 32'h200;
      dPend = 1'b1; dWr = 1'b1; dBoth = 1'b0; dAddr = 32'h300; dWdata = 32'hA5A5_0001;
      dHold = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (i == 5) dHold = 1'b0;
         grantStep();
         busyStep(0, $urandom);
      end
      for (int i = 0; i < 6; i++) begin
         checkOutput($sformatf("starve order %0d", i), 32'(ownLog[i]), 32'(expSeq[i]));
      end

      // Hung read aborted by the watchdog, then mem_ready on the abort cycle.
      dPend = 1'b1; dWr = 1'b0; dBoth = 1'b0; dAddr = 32'h44;
      grantStep();
      busyStep(-1, 32'h0);
      dPend = 1'b1; dWr = 1'b0; dAddr = 32'h48;
      grantStep();
      busyStep(TMO - 1, 32'h1234_5678);

      idleProbe();

      // Reset in the middle of a write.
      dPend = 1'b1; dWr = 1'b1; dBoth = 1'b0; dAddr = 32'h80; dWdata = 32'hCAFE_F00D;
      grantStep();
      applyStimulus();
      #1;
      checkOutput("pre-reset mem_wr", 32'(mem_wr), 32'h1);
      checkOutput("pre-reset mem_addr", mem_addr, 32'h80);
      reset = 1'b1;
      mem_ready = 1'b1;
      #1;
      checkOutput("midreset mem_wr", 32'(mem_wr), 32'h0);
      checkOutput("midreset mem_rd", 32'(mem_rd), 32'h0);
      checkOutput("midreset mem_addr", mem_addr, 32'h0);
      checkOutput("midreset mem_wdata", mem_wdata, 32'h0);
      checkOutput("midreset busy", 32'(busy), 32'h0);
      checkOutput("midreset dbus_ready", 32'(dbus_ready), 32'h0);
      checkOutput("midreset ibus_ready", 32'(ibus_ready), 32'h0);
      checkOutput("midreset err", 32'(err), 32'h0);
      nextCycle();
      reset = 1'b0;
      mem_ready = 1'b0;
      dPend = 1'b0;
      starveModel = 0;
      fPend = 1'b1; fAddr = 32'h104;
      grantStep();
      busyStep(1, 32'h0BAD_F00D);

      // Random traffic against the model.
      arrivals = 1'b1;
      for (int n = 0; n < 250; n++) begin
         int r;
         int lat;
         if (!fPend && $urandom_range(1) == 1) newFetch();
         if (!dPend && $urandom_range(2) != 0) newData();
         if (!fPend && !dPend) begin
            idleProbe();
            continue;
         end
         grantStep();
         r = $urandom_range(9);
         if (r < 7) lat = r % 4;
         else if (r == 7) lat = TMO - 1;
         else lat = -1;
         busyStep(lat, $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
